// File: rtl/tnn_seq_classifier.sv
// tnn_seq_classifier: sequential ternary-NN classifier evaluating LANES hidden neurons per cycle,
// with valid/ready handshakes; define TNN_SEQ_SCORES_EN to expose the per-class scores port.
module tnn_seq_classifier #(
    parameter int FEAT_CNT = 19,
    parameter int FEAT_BITS = 4,
    parameter int HIDDEN_CNT = 40,
    parameter int CLASS_CNT = 3,
    parameter int LANES = 8,
    parameter logic [FEAT_CNT*HIDDEN_CNT-1:0] W1_NZ = '1,
    parameter logic [FEAT_CNT*HIDDEN_CNT-1:0] W1_SIGN = '0,
    parameter logic [CLASS_CNT*HIDDEN_CNT-1:0] W2_NZ = '1,
    parameter logic [CLASS_CNT*HIDDEN_CNT-1:0] W2_SIGN = '0
) (
    input logic clk,
    input logic rst_n,
    input logic in_valid,
    output logic in_ready,
    input logic [FEAT_CNT*FEAT_BITS-1:0] features,
    output logic out_valid,
    input logic out_ready,
`ifdef TNN_SEQ_SCORES_EN
    output logic [$clog2(CLASS_CNT)-1:0] prediction,
    output logic [CLASS_CNT*$clog2(2*HIDDEN_CNT+1)-1:0] scores
`else
    output logic [$clog2(CLASS_CNT)-1:0] prediction
`endif
);
    localparam int NPASS = (HIDDEN_CNT + LANES - 1) / LANES;
    localparam int PW = NPASS > 1 ? $clog2(NPASS) : 1;
    localparam int AW = FEAT_BITS + 1 + $clog2(FEAT_CNT + 1);
    localparam int SW = $clog2(2 * HIDDEN_CNT + 1);
    localparam int CW = $clog2(CLASS_CNT);
    localparam int W1P = NPASS * LANES * FEAT_CNT;
    localparam int W2P = CLASS_CNT * HIDDEN_CNT + NPASS * LANES;
    // Padding keeps every constant lane index in range; padded lanes are masked by lane_ok.
    localparam logic [W1P-1:0] NZ1 = W1P'(W1_NZ);
    localparam logic [W1P-1:0] SG1 = W1P'(W1_SIGN);
    localparam logic [W2P-1:0] NZ2 = W2P'(W2_NZ);
    localparam logic [W2P-1:0] SG2 = W2P'(W2_SIGN);

    function automatic int zero_cnt(input int c);
        int n;
        n = 0;
        for (int j = 0; j < HIDDEN_CNT; j++) n += int'(!W2_NZ[c*HIDDEN_CNT+j]);
        return n;
    endfunction

    function automatic int min_zero_cnt();
        int m;
        m = zero_cnt(0);
        for (int c = 1; c < CLASS_CNT; c++) m = zero_cnt(c) < m ? zero_cnt(c) : m;
        return m;
    endfunction

    localparam int MINZC = min_zero_cnt();

    function automatic logic hidden_bit(input logic [FEAT_CNT-1:0] nz, input logic [FEAT_CNT-1:0] sg,
                                        input logic [FEAT_CNT*FEAT_BITS-1:0] f);
        logic signed [AW-1:0] s, x;
        s = '0;
        for (int k = 0; k < FEAT_CNT; k++) begin
            x = AW'(f[k*FEAT_BITS +: FEAT_BITS]);
            if (nz[k]) s = sg[k] ? s + x : s - x;
        end
        return s >= 0;
    endfunction

    typedef enum logic [1:0] {IDLE, RUN, SCORE, DONE} state_t;
    state_t state, next_state;

    logic accept, last_pass;
    logic [PW-1:0] pass;
    logic [FEAT_CNT*FEAT_BITS-1:0] feat_q;
    logic [FEAT_CNT-1:0] nz1 [LANES];
    logic [FEAT_CNT-1:0] sg1 [LANES];
    logic [CLASS_CNT-1:0] nz2 [LANES];
    logic [CLASS_CNT-1:0] sg2 [LANES];
    logic [LANES-1:0] lane_ok, h;
    logic [SW-1:0] match [CLASS_CNT];
    logic [SW-1:0] inc [CLASS_CNT];
    logic [SW-1:0] sc [CLASS_CNT];
    logic [SW-1:0] bv;
    logic [CW-1:0] best;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            in_ready <= 1'b0;
        end else begin
            state <= next_state;
            in_ready <= next_state == IDLE;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: next_state = accept ? RUN : IDLE;
            RUN: next_state = last_pass ? SCORE : RUN;
            SCORE: next_state = DONE;
            DONE: next_state = out_ready ? IDLE : DONE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        accept = state == IDLE && in_valid && in_ready;
        last_pass = pass == PW'(NPASS - 1);
        out_valid = state == DONE;
    end

    // Weight rows for the current pass, then per-class agreement counts across lanes.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            nz1[l] = '0;
            sg1[l] = '0;
            nz2[l] = '0;
            sg2[l] = '0;
            lane_ok[l] = 1'b0;
            for (int p = 0; p < NPASS; p++)
                if (pass == PW'(p)) begin
                    nz1[l] = NZ1[(p*LANES+l)*FEAT_CNT +: FEAT_CNT];
                    sg1[l] = SG1[(p*LANES+l)*FEAT_CNT +: FEAT_CNT];
                    lane_ok[l] = p * LANES + l < HIDDEN_CNT;
                    for (int c = 0; c < CLASS_CNT; c++) begin
                        nz2[l][c] = NZ2[c*HIDDEN_CNT+p*LANES+l];
                        sg2[l][c] = SG2[c*HIDDEN_CNT+p*LANES+l];
                    end
                end
            h[l] = hidden_bit(nz1[l], sg1[l], feat_q);
        end
        for (int c = 0; c < CLASS_CNT; c++) begin
            inc[c] = '0;
            for (int l = 0; l < LANES; l++)
                if (lane_ok[l] && nz2[l][c] && h[l] == sg2[l][c]) inc[c] = inc[c] + SW'(1);
        end
    end

    always_comb begin
        bv = '0;
        best = '0;
        for (int c = 0; c < CLASS_CNT; c++) begin
            sc[c] = SW'(2 * int'(match[c]) + zero_cnt(c) - MINZC);
            if (c == 0 || sc[c] > bv) begin
                bv = sc[c];
                best = CW'(c);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            feat_q <= '0;
            pass <= '0;
            prediction <= '0;
            for (int c = 0; c < CLASS_CNT; c++) match[c] <= '0;
`ifdef TNN_SEQ_SCORES_EN
            scores <= '0;
`endif
        end else begin
            if (accept) begin
                feat_q <= features;
                pass <= '0;
                for (int c = 0; c < CLASS_CNT; c++) match[c] <= '0;
            end else if (state == RUN) begin
                pass <= pass + 1'b1;
                for (int c = 0; c < CLASS_CNT; c++) match[c] <= match[c] + inc[c];
            end
            if (state == SCORE) begin
                prediction <= best;
`ifdef TNN_SEQ_SCORES_EN
                for (int c = 0; c < CLASS_CNT; c++) scores[c*SW +: SW] <= sc[c];
`endif
            end
        end
    end
endmodule

// File: tb/tb_tnn_seq_classifier.sv
// tb_tnn_seq_classifier: directed small-network scenarios plus random vectors on a full-size network,
// both checked against a whole-network arithmetic reference model.
module tb_tnn_seq_classifier;
    localparam int S_NPASS = 2;
    localparam int S_CYCLE = 1 + S_NPASS + 1 + 1;  // IDLE, RUN passes, SCORE, one DONE cycle
    localparam logic [5:0] S_W1_NZ = 6'b011011;
    localparam logic [5:0] S_W1_SG = 6'b001001;
    localparam logic [5:0] S_W2_NZ = 6'b100011;
    localparam logic [5:0] S_W2_SG = 6'b100011;
    localparam logic [759:0] B_W1_NZ = {20{38'h2FB7D6E9A5}};
    localparam logic [759:0] B_W1_SG = {19{40'h5A3C96E1B4}};
    localparam logic [119:0] B_W2_NZ = {8{15'h7DEF}};
    localparam logic [119:0] B_W2_SG = {3{40'hC3A59E176B}};

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_pred;
    logic [7:0] s_feat;
    logic b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [75:0] b_feat;
    logic [1:0] b_pred;
`ifdef TNN_SEQ_SCORES_EN
    logic [5:0] s_scores;
    logic [20:0] b_scores;
`endif

    int checks = 0;
    int fails = 0;

    tnn_seq_classifier #(.FEAT_CNT(2), .FEAT_BITS(4), .HIDDEN_CNT(3), .CLASS_CNT(2), .LANES(2),
        .W1_NZ(S_W1_NZ), .W1_SIGN(S_W1_SG), .W2_NZ(S_W2_NZ), .W2_SIGN(S_W2_SG)) u_small (
        .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready), .features(s_feat),
        .out_valid(s_out_valid), .out_ready(s_out_ready),
`ifdef TNN_SEQ_SCORES_EN
        .prediction(s_pred), .scores(s_scores)
`else
        .prediction(s_pred)
`endif
    );

    tnn_seq_classifier #(.W1_NZ(B_W1_NZ), .W1_SIGN(B_W1_SG), .W2_NZ(B_W2_NZ), .W2_SIGN(B_W2_SG)) u_big (
        .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready), .features(b_feat),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
`ifdef TNN_SEQ_SCORES_EN
        .prediction(b_pred), .scores(b_scores)
`else
        .prediction(b_pred)
`endif
    );

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Whole-network reference: every hidden neuron from plain integer sums, then scores and argmax.
    function automatic int model(input int fc, input int hc, input int cc, input logic [1023:0] w1n,
                                 input logic [1023:0] w1s, input logic [127:0] w2n, input logic [127:0] w2s,
                                 input logic [127:0] f, output logic [31:0] sc);
        int h [64];
        int zc [4];
        int mt [4];
        int scv [4];
        int s, v, minzc, best;
        for (int j = 0; j < hc; j++) begin
            s = 0;
            for (int k = 0; k < fc; k++)
                if (w1n[j*fc+k]) begin
                    v = int'(f[k*4 +: 4]);
                    s += w1s[j*fc+k] ? v : -v;
                end
            h[j] = s >= 0 ? 1 : 0;
        end
        minzc = 1 << 30;
        for (int c = 0; c < cc; c++) begin
            mt[c] = 0;
            zc[c] = 0;
            for (int j = 0; j < hc; j++)
                if (w2n[c*hc+j]) mt[c] += (h[j] == int'(w2s[c*hc+j])) ? 1 : 0;
                else zc[c]++;
            if (zc[c] < minzc) minzc = zc[c];
        end
        best = 0;
        sc = '0;
        for (int c = 0; c < cc; c++) begin
            scv[c] = 2 * mt[c] + zc[c] - minzc;
            sc[c*8 +: 8] = 8'(scv[c]);
            if (scv[c] > scv[best]) best = c;
        end
        return best;
    endfunction

    function automatic int s_model(input int f0, input int f1, output logic [31:0] sc);
        logic [127:0] f;
        f = '0;
        f[3:0] = f0[3:0];
        f[7:4] = f1[3:0];
        return model(2, 3, 2, 1024'(S_W1_NZ), 1024'(S_W1_SG), 128'(S_W2_NZ), 128'(S_W2_SG), f, sc);
    endfunction

    task automatic s_accept(input int f0, input int f1);
        int n;
        n = 0;
        while (!s_in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("s_ready_before_accept", int'(s_in_ready), 1);
        s_feat = {f1[3:0], f0[3:0]};
        s_in_valid = 1'b1;
        @(negedge clk);
        s_in_valid = 1'b0;
        s_feat = 8'($urandom);
    endtask

    task automatic s_result(input string tag, input int ep, input int e0, input int e1, input bit release_out);
        int n;
        n = 0;
        while (!s_out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_valid"}, int'(s_out_valid), 1);
        chk({tag, "_pred"}, int'(s_pred), ep);
`ifdef TNN_SEQ_SCORES_EN
        chk({tag, "_score0"}, int'(s_scores[2:0]), e0);
        chk({tag, "_score1"}, int'(s_scores[5:3]), e1);
`endif
        if (release_out) begin
            s_out_ready = 1'b1;
            @(negedge clk);
            s_out_ready = 1'b0;
            chk({tag, "_released"}, int'(s_out_valid), 0);
        end
    endtask

    task automatic scenario1(input string tag);
        s_accept(5, 3);
        for (int i = 0; i < 3; i++) begin
            chk({tag, "_early_valid"}, int'(s_out_valid), 0);
            chk({tag, "_busy"}, int'(s_in_ready), 0);
            @(negedge clk);
        end
        chk({tag, "_latency"}, int'(s_out_valid), 1);
        s_result(tag, 0, 4, 1, 1'b1);
    endtask

    initial begin
        int last, accepts, n, p, f0, f1;
        int expq [$];
        logic [31:0] sc;
        logic [75:0] f;
        rst_n = 1'b1;
        {s_in_valid, s_out_ready, b_in_valid, b_out_ready} = '0;
        s_feat = '0;
        b_feat = '0;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_s_in_ready", int'(s_in_ready), 0);
        chk("rst_s_out_valid", int'(s_out_valid), 0);
        chk("rst_s_pred", int'(s_pred), 0);
        chk("rst_b_in_ready", int'(b_in_ready), 0);
        chk("rst_b_out_valid", int'(b_out_valid), 0);
        chk("rst_b_pred", int'(b_pred), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_s_in_ready", int'(s_in_ready), 1);
        chk("rel_b_in_ready", int'(b_in_ready), 1);

        scenario1("s1");

        s_accept(0, 0);
        s_result("s3", 0, 4, 3, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("s3_hold_valid", int'(s_out_valid), 1);
            chk("s3_hold_pred", int'(s_pred), 0);
            chk("s3_hold_ready", int'(s_in_ready), 0);
        end
        s_out_ready = 1'b1;
        @(negedge clk);
        s_out_ready = 1'b0;
        chk("s3_out_cleared", int'(s_out_valid), 0);
        chk("s3_in_ready_back", int'(s_in_ready), 1);

        s_out_ready = 1'b1;
        s_in_valid = 1'b1;
        last = -1;
        accepts = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (s_out_valid) begin
                if (expq.size() == 0) chk("s4_spurious_valid", int'(s_out_valid), 0);
                else chk("s4_pred", int'(s_pred), expq.pop_front());
            end
            f0 = int'($urandom_range(0, 15));
            f1 = int'($urandom_range(0, 15));
            s_feat = {f1[3:0], f0[3:0]};
            if (s_in_ready) begin
                if (last >= 0) chk("s4_spacing", cyc - last, S_CYCLE);
                last = cyc;
                accepts++;
                expq.push_back(s_model(f0, f1, sc));
            end
            @(negedge clk);
        end
        s_in_valid = 1'b0;
        n = 0;
        while (expq.size() > 0 && n < 20) begin
            if (s_out_valid) chk("s4_pred_tail", int'(s_pred), expq.pop_front());
            @(negedge clk);
            n++;
        end
        chk("s4_drained", expq.size(), 0);
        chk("s4_accepts", accepts, 40 / S_CYCLE);
        s_out_ready = 1'b0;

        s_accept(0, 7);
        s_result("s2", 1, 2, 3, 1'b1);

        s_accept(5, 3);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("s6_rst_valid", int'(s_out_valid), 0);
        chk("s6_rst_pred", int'(s_pred), 0);
        chk("s6_rst_ready", int'(s_in_ready), 0);
        repeat (3) begin
            @(negedge clk);
            chk("s6_rst_hold_valid", int'(s_out_valid), 0);
            chk("s6_rst_hold_ready", int'(s_in_ready), 0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk("s6_no_stale_valid", int'(s_out_valid), 0);
        chk("s6_ready_after", int'(s_in_ready), 1);
        scenario1("s6_rerun");

        b_out_ready = 1'b1;
        for (int v = 0; v < 1000; v++) begin
            f = 76'({$urandom, $urandom, $urandom});
            n = 0;
            while (!b_in_ready && n < 50) begin
                @(negedge clk);
                n++;
            end
            b_feat = f;
            b_in_valid = 1'b1;
            @(negedge clk);
            b_in_valid = 1'b0;
            b_feat = 76'({$urandom, $urandom, $urandom});
            p = model(19, 40, 3, 1024'(B_W1_NZ), 1024'(B_W1_SG), 128'(B_W2_NZ), 128'(B_W2_SG), 128'(f), sc);
            n = 0;
            while (!b_out_valid && n < 50) begin
                @(negedge clk);
                n++;
            end
            chk("b_valid", int'(b_out_valid), 1);
            chk("b_pred", int'(b_pred), p);
`ifdef TNN_SEQ_SCORES_EN
            for (int c = 0; c < 3; c++) chk("b_score", int'(b_scores[c*7 +: 7]), int'(sc[c*8 +: 8]));
`endif
            @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
